fifo_read_ctrl: RTL

Read-side controller for the FIFO. It owns the read pointer, gates read requests against empty, and captures the addressed memory word into a registered output with a one-cycle valid strobe. It also derives the FIFO status flags (empty, full, threshold, level) from the read pointer and the write-side pointer, and holds sticky overflow/underflow error flags. It sits opposite the write-pointer block, sharing the memory array and the same clock and reset.

---
 rtl/fifo_read_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller: read pointer, gated reads, registered data out,
// status flags from both pointers, sticky overflow/underflow errors.
module fifo_read_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int THRESH = 4
) (
  input  logic              clk,
  input  logic              rst_edge,
  input  logic              rd_edge,
  input  logic              wr_edge,
  input  logic [ADDR_W:0]   wptr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              clr_err,
  output logic [ADDR_W:0]   rptr,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              fifo_threshold,
  output logic [ADDR_W:0]   fifo_level,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] THRESH_L = PW'(THRESH);
  localparam logic [PW-1:0] ONE = PW'(1);

  logic rd_reject;
  logic wr_reject;

  // Wrap bit distinguishes full from empty when indices match
  assign fifo_level = wptr - rptr;
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                      (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign fifo_threshold = (fifo_level >= THRESH_L);

  assign fifo_rd   = rd_edge & ~fifo_empty;
  assign rd_reject = rd_edge & fifo_empty;
  assign wr_reject = wr_edge & fifo_full;

  always_ff @(posedge clk or posedge rst_edge) begin
    if (rst_edge) begin
      rptr       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= fifo_rd;
      if (fifo_rd) begin
        rptr <= rptr + ONE;
        dout <= mem_rdata;
      end
    end
  end

  // A new error in the clearing cycle takes priority over the clear
  always_ff @(posedge clk or posedge rst_edge) begin
    if (rst_edge) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (wr_reject)
        fifo_overflow <= 1'b1;
      else if (clr_err)
        fifo_overflow <= 1'b0;
      if (rd_reject)
        fifo_underflow <= 1'b1;
      else if (clr_err)
        fifo_underflow <= 1'b0;
    end
  end

endmodule
